// File: rtl/cpu_bus_arbiter_mux_if.sv
// CPU-side memory bus bundle: picorv32-style native request/response plus
// the registered fan-out to N memory-mapped slaves and their returns.
interface cpu_bus_arbiter_mux_if #(
    parameter int unsigned NUM_SLAVES = 9
);
    logic                       cpu_valid;
    logic [31:0]                cpu_addr;
    logic [31:0]                cpu_wdata;
    logic [3:0]                 cpu_wstrb;
    logic                       force_trap;
    logic                       cpu_ready;
    logic [31:0]                cpu_rdata;
    logic [NUM_SLAVES-1:0]      slv_cs;
    logic                       slv_we;
    logic [3:0]                 slv_wstrb;
    logic [31:0]                slv_addr;
    logic [31:0]                slv_wdata;
    logic [NUM_SLAVES*32-1:0]   slv_rdata;
    logic [NUM_SLAVES-1:0]      slv_ready;

    // Environment view: drives CPU requests and slave returns.
    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap,
        output slv_rdata, slv_ready,
        input  cpu_ready, cpu_rdata,
        input  slv_cs, slv_we, slv_wstrb, slv_addr, slv_wdata
    );

    // Arbiter view: consumes CPU requests, drives the slave side.
    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap,
        input  slv_rdata, slv_ready,
        output cpu_ready, cpu_rdata,
        output slv_cs, slv_we, slv_wstrb, slv_addr, slv_wdata
    );
endinterface

// File: rtl/cpu_bus_arbiter_mux.sv
// Prefix-decoded CPU memory mux with a registered access FSM, per-access
// timeout for hung slaves, forced-trap responses and sticky error capture.
module cpu_bus_arbiter_mux #(
    parameter int unsigned NUM_SLAVES   = 9,
    parameter int unsigned PREFIX_LSB   = 24,
    parameter int unsigned PREFIX_WIDTH = 8,
    // ROM, RAM(area 1), TRNG, timer, UDS, UART, touch, FW RAM, TK1
    parameter logic [NUM_SLAVES*PREFIX_WIDTH-1:0] SLAVE_PREFIX_MAP = 72'hFF_D0_C4_C3_C2_C1_C0_40_00,
    parameter logic [NUM_SLAVES*PREFIX_WIDTH-1:0] SLAVE_MASK_MAP   = 72'hFF_FF_FF_FF_FF_FF_FF_C0_FF,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_bus_arbiter_mux_if.slave  bus,
    input  logic                  err_clear,
    output logic                  err_valid,
    output logic [1:0]            err_code,
    output logic [31:0]           err_addr,
    output logic [7:0]            err_count
);
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 state_r;
    logic [15:0]            timer_r;
    logic [IDX_W-1:0]       idx_r;
    logic [31:0]            resp_data_r;
    logic                   cpu_ready_r;
    logic [31:0]            cpu_rdata_r;
    logic [NUM_SLAVES-1:0]  slv_cs_r;
    logic                   slv_we_r;
    logic [3:0]             slv_wstrb_r;
    logic [31:0]            slv_addr_r;
    logic [31:0]            slv_wdata_r;
    logic                   err_valid_r;
    logic [1:0]             err_code_r;
    logic [31:0]            err_addr_r;
    logic [7:0]             err_count_r;

    logic [PREFIX_WIDTH-1:0] prefix_s;
    logic                    hit_s;
    logic [IDX_W-1:0]        hit_idx_s;
    logic [NUM_SLAVES-1:0]   hit_onehot_s;
    logic                    sel_ready_s;
    logic [31:0]             sel_rdata_s;
    logic                    timeout_hit_s;
    logic                    err_event_s;
    logic [1:0]              err_type_s;
    logic [31:0]             err_addr_new_s;

    // Prefix decode: scan downwards so the lowest matching slave index wins.
    always_comb begin
        prefix_s  = bus.cpu_addr[PREFIX_LSB +: PREFIX_WIDTH];
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (((prefix_s ^ SLAVE_PREFIX_MAP[i*PREFIX_WIDTH +: PREFIX_WIDTH]) &
                 SLAVE_MASK_MAP[i*PREFIX_WIDTH +: PREFIX_WIDTH]) == {PREFIX_WIDTH{1'b0}}) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // One-hot chip-select pattern for the decoded slave.
    always_comb begin
        hit_onehot_s = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit_onehot_s[i] = (hit_idx_s == IDX_W'(i));
        end
    end

    // Return path of the slave latched at accept time; others are ignored.
    always_comb begin
        sel_ready_s   = bus.slv_ready[idx_r];
        sel_rdata_s   = bus.slv_rdata[idx_r*32 +: 32];
        timeout_hit_s = (timer_r == 16'(TIMEOUT_CYCLES - 1));
    end

    // Error events: unmapped accepts in IDLE, expired timer in ACCESS.
    // A ready arriving on the timeout cycle wins over the timeout.
    always_comb begin
        err_event_s    = 1'b0;
        err_type_s     = 2'd0;
        err_addr_new_s = bus.cpu_addr;
        case (state_r)
            ST_IDLE: begin
                if (bus.cpu_valid && !cpu_ready_r && !bus.force_trap && !hit_s) begin
                    err_event_s = 1'b1;
                    err_type_s  = 2'd1;
                end else begin
                    err_event_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (bus.cpu_valid && !sel_ready_s && timeout_hit_s) begin
                    err_event_s    = 1'b1;
                    err_type_s     = 2'd2;
                    err_addr_new_s = slv_addr_r;
                end else begin
                    err_event_s = 1'b0;
                end
            end
            default: begin
                err_event_s = 1'b0;
            end
        endcase
    end

    // Access FSM; cpu_ready pulses on the cycle after RESP so that it and
    // all slave-side signals come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            timer_r     <= 16'd0;
            idx_r       <= {IDX_W{1'b0}};
            resp_data_r <= 32'h0000_0000;
            cpu_ready_r <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            slv_cs_r    <= {NUM_SLAVES{1'b0}};
            slv_we_r    <= 1'b0;
            slv_wstrb_r <= 4'h0;
            slv_addr_r  <= 32'h0000_0000;
            slv_wdata_r <= 32'h0000_0000;
        end else begin
            cpu_ready_r <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            case (state_r)
                ST_IDLE: begin
                    // A valid still high during the ready pulse is the old request.
                    if (bus.cpu_valid && !cpu_ready_r) begin
                        if (bus.force_trap) begin
                            resp_data_r <= ILLEGAL_INSTRUCTION;
                            state_r     <= ST_RESP;
                        end else if (!hit_s) begin
                            resp_data_r <= 32'h0000_0000;
                            state_r     <= ST_RESP;
                        end else begin
                            idx_r       <= hit_idx_s;
                            slv_cs_r    <= hit_onehot_s;
                            slv_we_r    <= |bus.cpu_wstrb;
                            slv_wstrb_r <= bus.cpu_wstrb;
                            slv_addr_r  <= bus.cpu_addr;
                            slv_wdata_r <= bus.cpu_wdata;
                            timer_r     <= 16'd0;
                            state_r     <= ST_ACCESS;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.cpu_valid) begin
                        slv_cs_r <= {NUM_SLAVES{1'b0}};
                        state_r  <= ST_IDLE;
                    end else if (sel_ready_s) begin
                        resp_data_r <= sel_rdata_s;
                        slv_cs_r    <= {NUM_SLAVES{1'b0}};
                        state_r     <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        resp_data_r <= 32'h0000_0000;
                        slv_cs_r    <= {NUM_SLAVES{1'b0}};
                        state_r     <= ST_RESP;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_RESP: begin
                    cpu_ready_r <= 1'b1;
                    cpu_rdata_r <= resp_data_r;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    slv_cs_r <= {NUM_SLAVES{1'b0}};
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky first-error capture; a clear coinciding with an error keeps the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_r <= 1'b0;
            err_code_r  <= 2'd0;
            err_addr_r  <= 32'h0000_0000;
            err_count_r <= 8'd0;
        end else begin
            if (err_event_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
            if (err_event_s && (!err_valid_r || err_clear)) begin
                err_valid_r <= 1'b1;
                err_code_r  <= err_type_s;
                err_addr_r  <= err_addr_new_s;
            end else if (err_clear) begin
                err_valid_r <= 1'b0;
                err_code_r  <= 2'd0;
                err_addr_r  <= 32'h0000_0000;
            end else begin
                err_valid_r <= err_valid_r;
            end
        end
    end

    assign bus.cpu_ready = cpu_ready_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.slv_cs    = slv_cs_r;
    assign bus.slv_we    = slv_we_r;
    assign bus.slv_wstrb = slv_wstrb_r;
    assign bus.slv_addr  = slv_addr_r;
    assign bus.slv_wdata = slv_wdata_r;
    assign err_valid     = err_valid_r;
    assign err_code      = err_code_r;
    assign err_addr      = err_addr_r;
    assign err_count     = err_count_r;
endmodule

// File: tb/tb_cpu_bus_arbiter_mux.sv
// Scenario bench for cpu_bus_arbiter_mux: expected responses are queued when
// a request is driven and popped when cpu_ready arrives.
module tb_cpu_bus_arbiter_mux;
    localparam int NS = 9;
    localparam int TO = 4;
    localparam logic [31:0] ILL = 32'h0BAD_C0DE;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clear;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    cpu_bus_arbiter_mux_if #(.NUM_SLAVES(NS)) bus();

    cpu_bus_arbiter_mux #(
        .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(TO),
        .ILLEGAL_INSTRUCTION(ILL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_clear(err_clear),
        .err_valid(err_valid),
        .err_code(err_code),
        .err_addr(err_addr),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Slave wait-cycle profile: ROM 2, RAM 1, TRNG never ready, rest combinational.
    function automatic int wait_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 1000;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rd_of(input int i);
        logic [31:0] v;
        if (i == 1) v = 32'hDEAD_BEEF;
        else        v = 32'hA500_0000 | 32'(i);
        return v;
    endfunction

    int cnt [NS];

    // Per-slave cycle counter while selected.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) cnt[i] <= bus.slv_cs[i] ? cnt[i] + 1 : 0;
    end

    // Slave returns; unselected slaves hold ready high as noise.
    always_comb begin
        bus.slv_ready = '0;
        bus.slv_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            bus.slv_ready[i]        = bus.slv_cs[i] ? (cnt[i] >= wait_of(i)) : 1'b1;
            bus.slv_rdata[i*32 +: 32] = rd_of(i);
        end
    end

    typedef struct { logic [31:0] rdata; int lat; } exp_t;
    typedef struct {
        logic [31:0] rdata; int lat; int cs_cycles; logic [NS-1:0] cs;
        logic [31:0] addr; logic [31:0] wdata; logic we; logic [3:0] wstrb; int leak;
    } obs_t;

    exp_t sb[$];
    exp_t e;
    obs_t o;
    int checks = 0;
    int passes = 0;

    task automatic push_exp(input logic [31:0] rdata, input int lat);
        exp_t x;
        x.rdata = rdata;
        x.lat   = lat;
        sb.push_back(x);
    endtask

    // Drive one request and record what the bus did until cpu_ready (bounded).
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic trap, output obs_t ob);
        ob.rdata = 32'h0; ob.lat = 0; ob.cs_cycles = 0; ob.cs = '0; ob.addr = 32'h0;
        ob.wdata = 32'h0; ob.we = 1'b0; ob.wstrb = 4'h0; ob.leak = 0;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        bus.cpu_wstrb = wstrb; bus.force_trap = trap;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.slv_cs != '0) begin
                ob.cs_cycles++; ob.cs = bus.slv_cs; ob.addr = bus.slv_addr;
                ob.wdata = bus.slv_wdata; ob.we = bus.slv_we; ob.wstrb = bus.slv_wstrb;
            end
            if (bus.cpu_ready) begin
                ob.rdata = bus.cpu_rdata; ob.lat = c;
                break;
            end else if (bus.cpu_rdata !== 32'h0) begin
                ob.leak++;
            end
        end
        @(posedge clk); #1;
        bus.cpu_valid = 1'b0; bus.force_trap = 1'b0; bus.cpu_wstrb = 4'h0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.cpu_ready, bus.slv_cs, bus.slv_we, bus.slv_wstrb} !== '0) $display("FAIL reset_ctl: got %h want 0", {bus.cpu_ready, bus.slv_cs, bus.slv_we, bus.slv_wstrb}); else passes++;
        checks++; if ({bus.cpu_rdata, bus.slv_addr, bus.slv_wdata} !== '0) $display("FAIL reset_data: got %h want 0", {bus.cpu_rdata, bus.slv_addr, bus.slv_wdata}); else passes++;
        checks++; if ({err_valid, err_code, err_addr, err_count} !== '0) $display("FAIL reset_err: got %h want 0", {err_valid, err_code, err_addr, err_count}); else passes++;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_ram_read();
        push_exp(32'hDEAD_BEEF, 4);
        run_access(32'h4000_0010, 32'h0, 4'h0, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.rdata !== e.rdata) $display("FAIL ram_rdata: got %h want %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.lat !== e.lat) $display("FAIL ram_lat: got %0d want %0d", o.lat, e.lat); else passes++;
        checks++; if (o.cs_cycles !== 2) $display("FAIL ram_cs_cycles: got %0d want 2", o.cs_cycles); else passes++;
        checks++; if (o.cs !== 9'b0_0000_0010) $display("FAIL ram_cs: got %b want 000000010", o.cs); else passes++;
        checks++; if (o.addr !== 32'h4000_0010) $display("FAIL ram_addr: got %h want 40000010", o.addr); else passes++;
        checks++; if (o.we !== 1'b0) $display("FAIL ram_we: got %b want 0", o.we); else passes++;
        checks++; if (o.leak !== 0) $display("FAIL ram_rdata_idle: got %0d nonzero cycles want 0", o.leak); else passes++;
    endtask

    task automatic test_timer_write();
        push_exp(32'hA500_0003, 3);
        run_access(32'hC100_0004, 32'h1234_5678, 4'hF, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.rdata !== e.rdata) $display("FAIL wr_rdata: got %h want %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.lat !== e.lat) $display("FAIL wr_lat: got %0d want %0d", o.lat, e.lat); else passes++;
        checks++; if (o.cs !== 9'b0_0000_1000) $display("FAIL wr_cs: got %b want 000001000", o.cs); else passes++;
        checks++; if ({o.we, o.wstrb} !== 5'b1_1111) $display("FAIL wr_we_wstrb: got %b want 11111", {o.we, o.wstrb}); else passes++;
        checks++; if (o.wdata !== 32'h1234_5678) $display("FAIL wr_wdata: got %h want 12345678", o.wdata); else passes++;
        checks++; if (err_count !== 8'd0) $display("FAIL wr_err_count: got %0d want 0", err_count); else passes++;
    endtask

    task automatic test_unmapped();
        push_exp(32'h0, 2);
        run_access(32'h8000_0000, 32'h0, 4'h0, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.rdata !== e.rdata) $display("FAIL um_rdata: got %h want %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.lat !== e.lat) $display("FAIL um_lat: got %0d want %0d", o.lat, e.lat); else passes++;
        checks++; if (o.cs_cycles !== 0) $display("FAIL um_cs: got %0d cycles want 0", o.cs_cycles); else passes++;
        checks++; if ({err_valid, err_code} !== 3'b1_01) $display("FAIL um_err: got %b want 101", {err_valid, err_code}); else passes++;
        checks++; if (err_addr !== 32'h8000_0000) $display("FAIL um_err_addr: got %h want 80000000", err_addr); else passes++;
        checks++; if (err_count !== 8'd1) $display("FAIL um_err_count: got %0d want 1", err_count); else passes++;
        pulse_clear();
        checks++; if ({err_valid, err_code, err_addr} !== '0) $display("FAIL um_clear: got %h want 0", {err_valid, err_code, err_addr}); else passes++;
        checks++; if (err_count !== 8'd1) $display("FAIL um_clear_count: got %0d want 1", err_count); else passes++;
    endtask

    task automatic test_timeout();
        push_exp(32'h0, 2 + TO);
        run_access(32'hC000_0000, 32'h0, 4'h0, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.rdata !== e.rdata) $display("FAIL to_rdata: got %h want %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.lat !== e.lat) $display("FAIL to_lat: got %0d want %0d", o.lat, e.lat); else passes++;
        checks++; if (o.cs_cycles !== TO) $display("FAIL to_cs_cycles: got %0d want %0d", o.cs_cycles, TO); else passes++;
        checks++; if ({err_valid, err_code} !== 3'b1_10) $display("FAIL to_err: got %b want 110", {err_valid, err_code}); else passes++;
        checks++; if (err_addr !== 32'hC000_0000) $display("FAIL to_err_addr: got %h want c0000000", err_addr); else passes++;
        checks++; if (err_count !== 8'd2) $display("FAIL to_err_count: got %0d want 2", err_count); else passes++;
        push_exp(32'h0, 2);
        run_access(32'h8000_1000, 32'h0, 4'h0, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.lat !== e.lat) $display("FAIL to_um_lat: got %0d want %0d", o.lat, e.lat); else passes++;
        checks++; if ({err_code, err_addr} !== {2'd2, 32'hC000_0000}) $display("FAIL to_sticky: got %h want 2c0000000", {err_code, err_addr}); else passes++;
        checks++; if (err_count !== 8'd3) $display("FAIL to_um_count: got %0d want 3", err_count); else passes++;
        pulse_clear();
        checks++; if (err_valid !== 1'b0) $display("FAIL to_clear: got %b want 0", err_valid); else passes++;
        checks++; if (err_count !== 8'd3) $display("FAIL to_clear_count: got %0d want 3", err_count); else passes++;
    endtask

    task automatic test_force_trap();
        push_exp(ILL, 2);
        run_access(32'h0000_0100, 32'h0, 4'h0, 1'b1, o);
        e = sb.pop_front();
        checks++; if (o.rdata !== e.rdata) $display("FAIL trap_rdata: got %h want %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.lat !== e.lat) $display("FAIL trap_lat: got %0d want %0d", o.lat, e.lat); else passes++;
        checks++; if (o.cs_cycles !== 0) $display("FAIL trap_cs: got %0d cycles want 0", o.cs_cycles); else passes++;
        checks++; if ({err_valid, err_count} !== {1'b0, 8'd3}) $display("FAIL trap_err: got %h want 003", {err_valid, err_count}); else passes++;
    endtask

    task automatic test_back_to_back();
        obs_t o2;
        push_exp(32'hA500_0000, 5);
        push_exp(32'hA500_0005, 3);
        run_access(32'h0000_0040, 32'h0, 4'h0, 1'b0, o);
        run_access(32'hC300_0000, 32'h0, 4'h0, 1'b0, o2);
        e = sb.pop_front();
        checks++; if ({o.rdata, o.lat} !== {e.rdata, e.lat}) $display("FAIL b2b_rom: got %h/%0d want %h/%0d", o.rdata, o.lat, e.rdata, e.lat); else passes++;
        e = sb.pop_front();
        checks++; if ({o2.rdata, o2.lat} !== {e.rdata, e.lat}) $display("FAIL b2b_uart: got %h/%0d want %h/%0d", o2.rdata, o2.lat, e.rdata, e.lat); else passes++;
    endtask

    task automatic test_abort();
        int rdy;
        rdy = 0;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 32'hC000_0000; bus.cpu_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        #1; bus.cpu_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.cpu_ready) rdy++;
        end
        checks++; if (rdy !== 0) $display("FAIL abort_ready: got %0d pulses want 0", rdy); else passes++;
        checks++; if (bus.slv_cs !== '0) $display("FAIL abort_cs: got %b want 0", bus.slv_cs); else passes++;
        checks++; if (err_count !== 8'd3) $display("FAIL abort_count: got %0d want 3", err_count); else passes++;
    endtask

    task automatic test_clear_collision();
        int seen;
        seen = 0;
        run_access(32'h8000_2000, 32'h0, 4'h0, 1'b0, o);
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 32'h8000_3000; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.cpu_ready) seen = 1;
        end
        @(posedge clk); #1; bus.cpu_valid = 1'b0;
        checks++; if (seen !== 1) $display("FAIL coll_ready: got %0d want 1", seen); else passes++;
        checks++; if ({err_valid, err_addr} !== {1'b1, 32'h8000_3000}) $display("FAIL coll_capture: got %h want 180003000", {err_valid, err_addr}); else passes++;
        checks++; if (err_count !== 8'd5) $display("FAIL coll_count: got %0d want 5", err_count); else passes++;
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        for (int k = 0; k < 260; k++) begin
            push_exp(32'h0, 2);
            run_access(32'h8100_0000 + 32'(k), 32'h0, 4'h0, 1'b0, o);
            e = sb.pop_front();
            if ({o.rdata, o.lat} !== {e.rdata, e.lat}) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL sat_resp: got %0d bad responses want 0", bad); else passes++;
        checks++; if (err_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", err_count); else passes++;
    endtask

    task automatic test_reset_mid_access();
        int rdy;
        rdy = 0;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 32'hC000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.slv_cs !== 9'b0_0000_0100) $display("FAIL rst_pre_cs: got %b want 000000100", bus.slv_cs); else passes++;
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if ({bus.slv_cs, bus.cpu_ready} !== '0) $display("FAIL rst_mid_ctl: got %b want 0", {bus.slv_cs, bus.cpu_ready}); else passes++;
        checks++; if ({err_valid, err_count} !== '0) $display("FAIL rst_mid_err: got %h want 0", {err_valid, err_count}); else passes++;
        @(posedge clk); #1; rst = 1'b0; bus.cpu_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_ready) rdy++;
        end
        checks++; if (rdy !== 0) $display("FAIL rst_no_resp: got %0d pulses want 0", rdy); else passes++;
        push_exp(32'hDEAD_BEEF, 4);
        run_access(32'h4000_0010, 32'h0, 4'h0, 1'b0, o);
        e = sb.pop_front();
        checks++; if ({o.rdata, o.lat} !== {e.rdata, e.lat}) $display("FAIL rst_after_read: got %h/%0d want %h/%0d", o.rdata, o.lat, e.rdata, e.lat); else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; err_clear = 1'b0;
        bus.cpu_valid = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.cpu_wstrb = 4'h0; bus.force_trap = 1'b0;
        test_reset();
        test_ram_read();
        test_timer_write();
        test_unmapped();
        test_timeout();
        test_force_trap();
        test_back_to_back();
        test_abort();
        test_clear_collision();
        test_saturation();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
